micro_sequencer: RTL and testbench

Parametrised microprogram sequencer. It is the next generation of our fixed 4-bit, 4-way-branch controller and drives the datapath control bus from an external microcode ROM. Additions over the current controller:
- generic condition selection
- micro-subroutine call/return stack
- wait-for-condition
- loop counter
- stall input
- error reporting

It sits between the microcode ROM and the datapath control bus.

---
 rtl/micro_sequencer_pkg.sv | 37 +++
 rtl/micro_sequencer_if.sv | 31 +++
 rtl/micro_stack.sv | 53 +++++
 rtl/micro_sequencer.sv | 138 +++++++++++++
 tb/tb_micro_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the microprogram sequencer: mode encodings and the
// microinstruction field layout, computed from the width parameters.
package micro_seq_pkg;

    typedef enum logic [2:0] {
        M_SEQ   = 3'd0,
        M_JMP   = 3'd1,
        M_BR4   = 3'd2,
        M_CALL  = 3'd3,
        M_RET   = 3'd4,
        M_WAIT  = 3'd5,
        M_LDCNT = 3'd6,
        M_DJNZ  = 3'd7
    } mode_e;

    localparam int MODE_W = 3;

    function automatic int mi_w(input int addr_w, input int csel_w, input int ctrl_w);
        return MODE_W + 2 * csel_w + 4 * addr_w + ctrl_w;
    endfunction

    // Address slots above ctrl, LSB first: 0=D, 1=C, 2=B, 3=A.
    function automatic int addr_lsb(input int ctrl_w, input int addr_w, input int slot);
        return ctrl_w + slot * addr_w;
    endfunction

    // Condition selects above the address fields: 0=csel0, 1=csel1.
    function automatic int csel_lsb(input int ctrl_w, input int addr_w, input int csel_w,
                                    input int slot);
        return ctrl_w + 4 * addr_w + slot * csel_w;
    endfunction

    function automatic int mode_lsb(input int ctrl_w, input int addr_w, input int csel_w);
        return ctrl_w + 4 * addr_w + 2 * csel_w;
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Bus between the sequencer, the microcode ROM and the datapath.
// master = sequencer side, slave = ROM/datapath/environment side.
interface micro_sequencer_if
    import micro_seq_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int CTRL_W   = 22,
    parameter int NUM_COND = 4,
    parameter int CSEL_W   = 2,
    parameter int SP_W     = 3
);
    localparam int MI_W = mi_w(ADDR_W, CSEL_W, CTRL_W);

    logic                stall;
    logic [NUM_COND-1:0] cond;
    logic [ADDR_W-1:0]   rom_addr;
    logic [MI_W-1:0]     rom_data;
    logic [CTRL_W-1:0]   ctrl;
    logic                err;
    logic [SP_W-1:0]     sp;

    modport master (
        input  stall, cond, rom_data,
        output rom_addr, ctrl, err, sp
    );

    modport slave (
        output stall, cond, rom_data,
        input  rom_addr, ctrl, err, sp
    );
endinterface

// File: rtl/micro_stack.sv
// Return-address LIFO; push/pop take effect on the clock edge, pop_dat shows the top entry.
// Push when full and pop when empty are ignored; the caller owns fault handling.
module micro_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     push_dat,
    output logic [W-1:0]     pop_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d, top_cnt;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    assign top_cnt = count_q - CNT_W'(1);
    assign wr_idx  = count_q[IDX_W-1:0];
    assign rd_idx  = top_cnt[IDX_W-1:0];
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_dat = mem_q[rd_idx];
    assign count   = count_q;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push && !full) begin
            mem_d[wr_idx] = push_dat;
            count_d       = count_q + CNT_W'(1);
        end else if (pop && !empty) begin
            count_d = top_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: next micro-address one cycle after the ROM word/conditions are seen.
// stall freezes all state and blanks ctrl; stack faults set a sticky err and divert to ERR_ADDR.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int CTRL_W      = 22,
    parameter int NUM_COND    = 4,
    parameter int CSEL_W      = 2,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 8,
    parameter int RESET_ADDR  = 0,
    parameter int ERR_ADDR    = 15
) (
    input logic               clk,
    input logic               rst,
    micro_sequencer_if.master bus
);
    localparam int SP_W     = $clog2(STACK_DEPTH + 1);
    localparam int MODE_LSB = mode_lsb(CTRL_W, ADDR_W, CSEL_W);
    localparam int C1_LSB   = csel_lsb(CTRL_W, ADDR_W, CSEL_W, 1);
    localparam int C0_LSB   = csel_lsb(CTRL_W, ADDR_W, CSEL_W, 0);
    localparam int A_LSB    = addr_lsb(CTRL_W, ADDR_W, 3);
    localparam int B_LSB    = addr_lsb(CTRL_W, ADDR_W, 2);
    localparam int C_LSB    = addr_lsb(CTRL_W, ADDR_W, 1);
    localparam int D_LSB    = addr_lsb(CTRL_W, ADDR_W, 0);

    mode_e                mode;
    logic [CSEL_W-1:0]    csel0, csel1;
    logic [ADDR_W-1:0]    fa, fb, fc, fd, seq_addr, ret_addr;
    logic [2**CSEL_W-1:0] cond_pad;
    logic                 k0, k1;
    logic                 push, pop, stk_full, stk_empty;
    logic [SP_W-1:0]      sp;

    logic [ADDR_W-1:0]    upc_q, upc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;

    assign mode     = mode_e'(bus.rom_data[MODE_LSB +: MODE_W]);
    assign csel1    = bus.rom_data[C1_LSB +: CSEL_W];
    assign csel0    = bus.rom_data[C0_LSB +: CSEL_W];
    assign fa       = bus.rom_data[A_LSB +: ADDR_W];
    assign fb       = bus.rom_data[B_LSB +: ADDR_W];
    assign fc       = bus.rom_data[C_LSB +: ADDR_W];
    assign fd       = bus.rom_data[D_LSB +: ADDR_W];
    assign seq_addr = upc_q + 1'b1;

    // Unimplemented condition selects read as 0 via zero padding.
    always_comb begin
        cond_pad               = '0;
        cond_pad[NUM_COND-1:0] = bus.cond;
    end
    assign k1 = cond_pad[csel1];
    assign k0 = cond_pad[csel0];

    micro_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W), .CNT_W(SP_W)) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .push_dat (seq_addr),
        .pop_dat  (ret_addr),
        .full     (stk_full),
        .empty    (stk_empty),
        .count    (sp)
    );

    always_comb begin
        upc_d = upc_q;
        cnt_d = cnt_q;
        err_d = err_q;
        push  = 1'b0;
        pop   = 1'b0;
        if (!bus.stall) begin
            unique case (mode)
                M_SEQ: upc_d = seq_addr;
                M_JMP: upc_d = fa;
                M_BR4: begin
                    unique case ({k1, k0})
                        2'b00:   upc_d = fa;
                        2'b01:   upc_d = fb;
                        2'b10:   upc_d = fc;
                        default: upc_d = fd;
                    endcase
                end
                M_CALL: begin
                    if (stk_full) begin
                        err_d = 1'b1;
                        upc_d = ADDR_W'(ERR_ADDR);
                    end else begin
                        push  = 1'b1;
                        upc_d = fa;
                    end
                end
                M_RET: begin
                    if (stk_empty) begin
                        err_d = 1'b1;
                        upc_d = ADDR_W'(ERR_ADDR);
                    end else begin
                        pop   = 1'b1;
                        upc_d = ret_addr;
                    end
                end
                M_WAIT: if (k0) upc_d = fa;
                M_LDCNT: begin
                    cnt_d = CNT_W'({fd, fc});
                    upc_d = fa;
                end
                default: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                        upc_d = fa;
                    end else begin
                        upc_d = fb;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc_q <= ADDR_W'(RESET_ADDR);
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            upc_q <= upc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.rom_addr = upc_q;
    assign bus.err      = err_q;
    assign bus.sp       = sp;
    assign bus.ctrl     = (bus.stall || rst) ? '0 : bus.rom_data[CTRL_W-1:0];
endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed scenarios plus random microcode, checked
// against a queue-based behavioural model of the sequencing rules.
module tb_micro_sequencer;
    localparam int ADDR_W = 4, CTRL_W = 22, NUM_COND = 4, CSEL_W = 2;
    localparam int STACK_DEPTH = 4, CNT_W = 8, RESET_ADDR = 0, ERR_ADDR = 15;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int MI_W  = 3 + 2 * CSEL_W + 4 * ADDR_W + CTRL_W;
    localparam int DEPTH = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    micro_sequencer_if #(.ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .NUM_COND(NUM_COND),
                         .CSEL_W(CSEL_W), .SP_W(SP_W)) bus ();

    micro_sequencer #(.ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .NUM_COND(NUM_COND), .CSEL_W(CSEL_W),
                      .STACK_DEPTH(STACK_DEPTH), .CNT_W(CNT_W), .RESET_ADDR(RESET_ADDR),
                      .ERR_ADDR(ERR_ADDR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [MI_W-1:0] rom [DEPTH];
    assign bus.rom_data = rom[bus.rom_addr];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int m_upc, m_cnt;
    bit m_err;
    int m_stk[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [MI_W-1:0] mk(input int mode, input int c1, input int c0,
                                           input int a, input int b, input int c, input int d,
                                           input int ctl);
        return {3'(mode), CSEL_W'(c1), CSEL_W'(c0), ADDR_W'(a), ADDR_W'(b), ADDR_W'(c),
                ADDR_W'(d), CTRL_W'(ctl)};
    endfunction

    task automatic fill_seq(input int base);
        for (int i = 0; i < DEPTH; i++) rom[i] = mk(0, 0, 0, 0, 0, 0, 0, base + i);
    endtask

    function automatic void model_reset();
        m_upc = RESET_ADDR;
        m_cnt = 0;
        m_err = 0;
        m_stk.delete();
    endfunction

    function automatic void model_step(input bit st, input logic [NUM_COND-1:0] cd);
        logic [MI_W-1:0] w;
        int mode, c1, c0, a, b, c, d, idx;
        bit k1, k0;
        if (st) return;
        w    = rom[ADDR_W'(m_upc)];
        mode = int'(w[MI_W-1 -: 3]);
        c1   = int'(w[MI_W-4 -: CSEL_W]);
        c0   = int'(w[MI_W-4-CSEL_W -: CSEL_W]);
        a    = int'(w[CTRL_W+3*ADDR_W +: ADDR_W]);
        b    = int'(w[CTRL_W+2*ADDR_W +: ADDR_W]);
        c    = int'(w[CTRL_W+ADDR_W +: ADDR_W]);
        d    = int'(w[CTRL_W +: ADDR_W]);
        k1   = (c1 < NUM_COND) ? cd[c1] : 1'b0;
        k0   = (c0 < NUM_COND) ? cd[c0] : 1'b0;
        case (mode)
            0: m_upc = (m_upc + 1) % DEPTH;
            1: m_upc = a;
            2: begin
                idx = 2 * int'(k1) + int'(k0);
                m_upc = (idx == 0) ? a : (idx == 1) ? b : (idx == 2) ? c : d;
            end
            3: if (m_stk.size() == STACK_DEPTH) begin
                   m_err = 1; m_upc = ERR_ADDR;
               end else begin
                   m_stk.push_back((m_upc + 1) % DEPTH); m_upc = a;
               end
            4: if (m_stk.size() == 0) begin
                   m_err = 1; m_upc = ERR_ADDR;
               end else begin
                   m_upc = m_stk.pop_back();
               end
            5: if (k0) m_upc = a;
            6: begin
                m_cnt = (d * DEPTH + c) % (1 << CNT_W);
                m_upc = a;
            end
            default: if (m_cnt != 0) begin
                m_cnt = m_cnt - 1; m_upc = a;
            end else begin
                m_upc = b;
            end
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        logic [MI_W-1:0] w;
        logic [CTRL_W-1:0] ectl;
        w    = rom[ADDR_W'(m_upc)];
        ectl = (rst || bus.stall) ? '0 : w[CTRL_W-1:0];
        chk({tag, ".rom_addr"}, 64'(bus.rom_addr), 64'(m_upc));
        chk({tag, ".ctrl"}, 64'(bus.ctrl), 64'(ectl));
        chk({tag, ".sp"}, 64'(bus.sp), 64'(m_stk.size()));
        chk({tag, ".err"}, 64'(bus.err), 64'(m_err));
    endtask

    // Entered and left at a falling edge; the rising edge falls in between.
    task automatic cycle(input string tag, input bit st, input logic [NUM_COND-1:0] cd,
                         input int exp_addr);
        bus.stall = st;
        bus.cond  = cd;
        #1;
        if (exp_addr >= 0) chk({tag, ".seq"}, 64'(bus.rom_addr), 64'(exp_addr));
        check_outputs(tag);
        model_step(st, cd);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.cond = '0;
        model_reset();
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] r64;
        int visits;
        rst = 1'b0;
        bus.stall = 1'b0;
        bus.cond = '0;
        fill_seq(0);
        @(negedge clk);

        // 1: straight sequencing with wrap, ctrl = address
        do_reset();
        for (int i = 0; i <= DEPTH; i++) cycle("t1", 0, '0, i % DEPTH);

        // 2: four-way branch
        fill_seq(32'h100);
        rom[3] = mk(2, 0, 1, 4, 5, 6, 7, 32'h2AA);
        do_reset();
        for (int i = 0; i < 3; i++) cycle("t2", 0, '0, i);
        cycle("t2", 0, 4'b0010, 3);
        cycle("t2", 0, '0, 5);
        do_reset();
        for (int i = 0; i < 3; i++) cycle("t2b", 0, '0, i);
        cycle("t2b", 0, 4'b0011, 3);
        cycle("t2b", 0, '0, 7);

        // 3: call/return, then stack overflow
        fill_seq(32'h200);
        rom[2] = mk(3, 0, 0, 8, 0, 0, 0, 32'h222);
        rom[9] = mk(4, 0, 0, 0, 0, 0, 0, 32'h299);
        do_reset();
        cycle("t3", 0, '0, 0);
        cycle("t3", 0, '0, 1);
        cycle("t3", 0, '0, 2);
        chk("t3.sp_in_sub", 64'(bus.sp), 64'd1);
        cycle("t3", 0, '0, 8);
        cycle("t3", 0, '0, 9);
        cycle("t3", 0, '0, 3);
        chk("t3.sp_after_ret", 64'(bus.sp), 64'd0);
        for (int i = 0; i < 5; i++) rom[i] = mk(3, 0, 0, i + 1, 0, 0, 0, 32'h300 + i);
        do_reset();
        for (int i = 0; i < 5; i++) cycle("t3n", 0, '0, i);
        chk("t3n.err", 64'(bus.err), 64'd1);
        chk("t3n.err_addr", 64'(bus.rom_addr), 64'(ERR_ADDR));
        chk("t3n.sp_full", 64'(bus.sp), 64'(STACK_DEPTH));
        cycle("t3n", 0, '0, ERR_ADDR);

        // 4: LDCNT 3 then DJNZ loop visits address 2 four times
        fill_seq(32'h400);
        rom[1] = mk(6, 0, 0, 2, 0, 3, 0, 32'h411);
        rom[2] = mk(7, 0, 0, 2, 4, 0, 0, 32'h422);
        do_reset();
        visits = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.rom_addr == 2) visits++;
            cycle("t4", 0, '0, (i < 2) ? i : 2);
        end
        chk("t4.exit", 64'(bus.rom_addr), 64'd4);
        chk("t4.visits", 64'(visits), 64'd4);

        // 5: wait-for-condition, then stall
        fill_seq(32'h500);
        rom[6] = mk(5, 0, 0, 7, 0, 0, 0, 32'h566);
        do_reset();
        for (int i = 0; i < 6; i++) cycle("t5", 0, '0, i);
        for (int i = 0; i < 3; i++) cycle("t5w", 0, 4'b1110, 6);
        cycle("t5w", 0, 4'b0001, 6);
        cycle("t5s", 0, '0, 7);
        cycle("t5s", 1, '0, 8);
        chk("t5s.ctrl_blank", 64'(bus.ctrl), 64'd0);
        cycle("t5s", 1, '0, 8);
        cycle("t5s", 0, '0, 8);
        cycle("t5s", 0, '0, 9);

        // 6: async reset mid-loop with two return addresses stacked
        fill_seq(32'h600);
        rom[0] = mk(3, 0, 0, 1, 0, 0, 0, 32'h6A0);
        rom[1] = mk(3, 0, 0, 2, 0, 0, 0, 32'h6A1);
        rom[2] = mk(6, 0, 0, 3, 0, 5, 0, 32'h6A2);
        rom[3] = mk(7, 0, 0, 3, 4, 0, 0, 32'h6A3);
        do_reset();
        for (int i = 0; i < 5; i++) cycle("t6", 0, '0, (i < 3) ? i : 3);
        chk("t6.sp_pre", 64'(bus.sp), 64'd2);
        bus.stall = 1'b0;
        bus.cond = '0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t6.arst_addr", 64'(bus.rom_addr), 64'(RESET_ADDR));
        chk("t6.arst_sp", 64'(bus.sp), 64'd0);
        chk("t6.arst_ctrl", 64'(bus.ctrl), 64'd0);
        check_outputs("t6.arst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) cycle("t6r", 0, '0, (i < 3) ? i : -1);

        // Random microcode and inputs
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < DEPTH; i++) begin
                r64 = {$urandom(), $urandom()};
                rom[i] = r64[MI_W-1:0];
            end
            do_reset();
            for (int i = 0; i < 150; i++)
                cycle("rnd", $urandom_range(0, 4) == 0, NUM_COND'($urandom()), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
